// File: rtl/divider_unit.sv
// Iterative RV32IM DIV/DIVU/REM/REMU unit: one restoring quotient bit per cycle,
// with single-cycle completion for divide-by-zero and signed overflow.
module divider_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      FINISH
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] quot_reg, quot_next;
   logic [XLEN-1:0] divisor_reg, divisor_next;
   logic [XLEN-1:0] rem_reg, rem_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [XLEN-1:0] result_reg, result_next;
   logic            is_rem_reg, is_rem_next;
   logic            neg_q_reg, neg_q_next;
   logic            neg_r_reg, neg_r_next;
   logic            busy_reg, done_reg;

   // Operation decode at capture time; unlisted codes fall through to DIVU.
   logic            op_signed, op_rem, div_zero, overflow;
   logic [XLEN-1:0] op1_abs, op2_abs;

   assign op_signed = (func3 == 3'b100) || (func3 == 3'b110);
   assign op_rem    = (func3 == 3'b110) || (func3 == 3'b111);
   assign div_zero  = (operand2 == '0);
   assign overflow  = op_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (operand2 == '1);
   assign op1_abs   = (op_signed && operand1[XLEN-1]) ? -operand1 : operand1;
   assign op2_abs   = (op_signed && operand2[XLEN-1]) ? -operand2 : operand2;

   // One restoring step: shift in the next dividend bit, trial-subtract 33-bit.
   logic [XLEN:0]   rem_shift, rem_diff;
   logic            step_ok;
   logic [XLEN-1:0] rem_step, quot_step, quot_fix, rem_fix;

   assign rem_shift = {rem_reg, quot_reg[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, divisor_reg};
   assign step_ok   = ~rem_diff[XLEN];
   assign rem_step  = step_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
   assign quot_step = {quot_reg[XLEN-2:0], step_ok};
   assign quot_fix  = neg_q_reg ? -quot_step : quot_step;
   assign rem_fix   = neg_r_reg ? -rem_step : rem_step;

   always_comb begin
      state_next   = state_reg;
      quot_next    = quot_reg;
      divisor_next = divisor_reg;
      rem_next     = rem_reg;
      count_next   = count_reg;
      result_next  = result_reg;
      is_rem_next  = is_rem_reg;
      neg_q_next   = neg_q_reg;
      neg_r_next   = neg_r_reg;

      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE, FINISH: begin
               if (start) begin
                  is_rem_next = op_rem;
                  neg_q_next  = op_signed && (operand1[XLEN-1] ^ operand2[XLEN-1]);
                  neg_r_next  = op_signed && operand1[XLEN-1];
                  if (div_zero) begin
                     result_next = op_rem ? operand1 : '1;
                     state_next  = FINISH;
                  end else if (overflow) begin
                     result_next = op_rem ? '0 : operand1;
                     state_next  = FINISH;
                  end else begin
                     quot_next    = op1_abs;
                     divisor_next = op2_abs;
                     rem_next     = '0;
                     count_next   = CW'(XLEN - 1);
                     state_next   = DIVIDE;
                  end
               end else if (state_reg == FINISH) begin
                  state_next = IDLE;
               end
            end
            DIVIDE: begin
               quot_next = quot_step;
               rem_next  = rem_step;
               if (count_reg == '0) begin
                  result_next = is_rem_reg ? rem_fix : quot_fix;
                  state_next  = FINISH;
               end else begin
                  count_next = count_reg - 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         quot_reg    <= '0;
         divisor_reg <= '0;
         rem_reg     <= '0;
         count_reg   <= '0;
         result_reg  <= '0;
         is_rem_reg  <= 1'b0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         quot_reg    <= quot_next;
         divisor_reg <= divisor_next;
         rem_reg     <= rem_next;
         count_reg   <= count_next;
         result_reg  <= result_next;
         is_rem_reg  <= is_rem_next;
         neg_q_reg   <= neg_q_next;
         neg_r_reg   <= neg_r_next;
         busy_reg    <= (state_next == DIVIDE);
         done_reg    <= (state_next == FINISH);
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed cases plus randomized ops
// against a plain-arithmetic RV32M reference.
module tb_divider_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  func3;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_result = '0;

   divider_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .func3    (func3),
      .operand1 (operand1),
      .operand2 (operand2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      bit sgn = (f3 == 3'b100) || (f3 == 3'b110);
      bit rem = (f3 == 3'b110) || (f3 == 3'b111);
      int sa = $signed(a);
      int sb = $signed(b);
      if (b == 0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
         return rem ? 32'(sa % sb) : 32'(sa / sb);
      end
      return rem ? a % b : a / b;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      bit sgn = (f3 == 3'b100) || (f3 == 3'b110);
      if (b == 0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Called at a negedge; returns at the negedge just after the capturing edge.
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      func3    = f3;
      operand1 = a;
      operand2 = b;
      @(negedge clk);
      start    = 1'b0;
      func3    = 3'($urandom);
      operand1 = $urandom;
      operand2 = $urandom;
   endtask

   // Leaves the bench at the negedge of the DONE cycle.
   task automatic op_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
      logic [31:0] exp_res = ref_result(f3, a, b);
      int exp_lat = ref_latency(f3, a, b);
      int lat = 1;
      int busy_cyc = 0;
      launch(f3, a, b);
      while (done !== 1'b1 && lat < 60) begin
         if (busy === 1'b1) busy_cyc++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      check({tag, "_result"}, result, exp_res);
      last_result = exp_res;
      $display("op %s f3=%b a=%h b=%h result=%h exp=%h lat=%0d", tag, f3, a, b, result,
               exp_res, lat);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      check({tag, "_result_hold"}, result, last_result);
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      func3 = 3'b000;
      operand1 = '0;
      operand2 = '0;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op_check("divu_100_7", 3'b101, 32'd100, 32'd7);
      idle_check("divu_100_7");
      op_check("remu_100_7", 3'b111, 32'd100, 32'd7);
      idle_check("remu_100_7");
      op_check("div_m100_7", 3'b100, 32'hFFFF_FF9C, 32'd7);
      idle_check("div_m100_7");
      op_check("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
      idle_check("rem_m7_2");
      op_check("div_by0", 3'b100, 32'd1234, 32'd0);
      idle_check("div_by0");
      op_check("rem_by0", 3'b110, 32'd1234, 32'd0);
      idle_check("rem_by0");
      op_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      idle_check("div_ovf");
      op_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      idle_check("rem_ovf");

      // Flush mid-divide: no DONE and the previous result survives.
      launch(3'b101, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_done", 32'(done), 32'd0);
      check("flush_result", result, last_result);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      check("flush_no_done", done_seen, 0);
      op_check("divu_9_3", 3'b101, 32'd9, 32'd3);
      idle_check("divu_9_3");

      // Asynchronous reset in the middle of an iteration.
      launch(3'b101, 32'd5000, 32'd17);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_result = '0;
      @(negedge clk);
      check("post_rst_result", result, 32'd0);

      // Back-to-back: START held in the DONE cycle.
      op_check("b2b_first", 3'b101, 32'd77, 32'd5);
      op_check("b2b_second", 3'b100, 32'hFFFF_F000, 32'd9);
      idle_check("b2b_second");

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3 = 3'($urandom_range(0, 7));
         logic [31:0] a = $urandom;
         logic [31:0] b = $urandom;
         int mode = $urandom_range(0, 9);
         case (mode)
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: begin a = 32'($urandom_range(0, 255)); b = {1'b1, 31'($urandom)}; end
            default: ;
         endcase
         op_check($sformatf("rand%0d", i), f3, a, b);
         if ($urandom_range(0, 1) == 0) idle_check($sformatf("rand%0d", i));
      end
      idle_check("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/divider_unit.md
# divider_unit

Iterative RV32IM divide/remainder unit in the EX stage, directly downstream of the register file. It takes the two source operands read from the register file (via ID/EX) and computes DIV, DIVU, REM or REMU at one quotient bit per cycle. It raises BUSY so the hazard unit can stall the pipeline, then presents a one-cycle DONE with the 32-bit result for the EX/MEM register and writeback.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request a divide; sampled only in IDLE or DONE.
- FUNC3  input  3  operation: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; other codes are treated as DIVU.
- OPERAND1  input  XLEN  dividend (rs1 data).
- OPERAND2  input  XLEN  divisor (rs2 data).
- FLUSH  input  1  synchronous abort from the branch/hazard logic.
- BUSY  output  1  high while iterating; the pipeline stalls on BUSY.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  XLEN  quotient or remainder, held until the next accepted START.

## Operation
- States: IDLE, DIVIDE, FINISH.
- IDLE / FINISH with START=1 and FLUSH=0: capture FUNC3 and the operands.
  - Divisor == 0: go to FINISH. RESULT = 32'hFFFFFFFF for DIV/DIVU; RESULT = OPERAND1 for REM/REMU.
  - DIV/REM with dividend 32'h80000000 and divisor 32'hFFFFFFFF: go to FINISH. RESULT = 32'h80000000 for DIV, 0 for REM.
  - Otherwise:
    - Load |dividend| and |divisor|; absolute values apply only to signed ops, unsigned ops use the raw values.
    - Clear the 33-bit partial remainder, set the iteration counter to 31, go to DIVIDE.
- DIVIDE: each cycle performs one restoring step.
  - Shift {remainder, quotient} left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor (33-bit). If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - When the counter reaches 0, apply sign fix-up, write RESULT and go to FINISH. Otherwise decrement the counter.
- Sign fix-up (signed ops only):
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- FINISH: DONE=1 for exactly one cycle.
  - With START=1, a new operation is accepted in the same cycle.
  - Otherwise go to IDLE.
- START in DIVIDE is ignored.
- FLUSH=1, in any state: go to IDLE next edge, no DONE, RESULT unchanged. FLUSH has priority over START and over completion.

## Timing
- Reset (RESET=0, asynchronous): state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal registers cleared.
  - Takes effect mid-operation without waiting for CLK.
  - Operation resumes on the first CLK edge after RESET returns to 1.
- Normal latency, with edge E0 capturing START:
  - BUSY=1 after E0 through E32.
  - Counter update at edges E1..E32.
  - DONE=1 and RESULT valid during the cycle after E32, i.e. 33 cycles after capture.
- Special cases (divide by zero, signed overflow): BUSY stays 0; DONE=1 in the cycle after E0 (1-cycle latency).
- BUSY and DONE are registered, never both high.
- RESULT changes only on the edge entering FINISH.
- Back-to-back: START held in FINISH gives BUSY=1 on the very next cycle, so there are no idle cycles between operations.
- The upstream stage must hold OPERAND1/2 and FUNC3 stable only in the START cycle; they are registered at E0.

## Test plan
- Reset with RESET=0, then DIVU 100 / 7 -> BUSY high for 32 cycles, DONE at cycle 33, RESULT=14. Repeat with REMU -> RESULT=2.
- DIV 32'hFFFFFF9C (-100) / 7 -> RESULT=32'hFFFFFFF2 (-14). REM -7 / 2 -> RESULT=32'hFFFFFFFF (-1).
- DIV 1234 / 0 -> DONE one cycle after START, RESULT=32'hFFFFFFFF, BUSY never high. REM 1234 / 0 -> RESULT=1234.
- DIV 32'h80000000 / 32'hFFFFFFFF -> RESULT=32'h80000000 in 1 cycle. REM with the same operands -> 0.
- Start DIVU 1000 / 3 and pulse FLUSH at cycle 10 -> IDLE next cycle, no DONE, RESULT keeps its previous value.
  - Then START DIVU 9 / 3 -> RESULT=3 after 33 cycles.
- Start DIVU and drop RESET to 0 asynchronously mid-iteration -> BUSY, DONE and RESULT = 0 immediately.
  - Separately: START held in FINISH -> second result delivered 33 cycles later with no gap.
